// File: rtl/petris_pkg.sv
// Shared types and constants for the playfield renderer.
//   colour_t      : 3-bit RGB pixel
//   shade_t       : 2-bit glyph pixel shade code
//   region_t      : screen region class of a scan position
//   TILE_SHIFT    : log2 of the tile size in screen pixels
//   GLYPH_ROW_W   : bits per glyph row (8 pixels x 2 bits)
//   GLYPH_ROWS    : rows per glyph
//   ENTRY_*       : bit positions of colour and code in a board entry
//   DEF_*         : default playfield geometry
package petris_pkg;

    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        SHADE_BG    = 2'd0,
        SHADE_TILE  = 2'd1,
        SHADE_WHITE = 2'd2,
        SHADE_BLACK = 2'd3
    } shade_t;

    typedef enum logic [1:0] {
        REGION_OUTSIDE = 2'd0,
        REGION_BORDER  = 2'd1,
        REGION_FIELD   = 2'd2
    } region_t;

    localparam int TILE_SHIFT  = 4;
    localparam int TILE_PIX    = 1 << TILE_SHIFT;
    localparam int GLYPH_ROW_W = 16;
    localparam int GLYPH_ROWS  = 8;

    localparam int ENTRY_COLOUR_HI = 10;
    localparam int ENTRY_COLOUR_LO = 8;
    localparam int ENTRY_CODE_HI   = 7;
    localparam int ENTRY_CODE_LO   = 0;

    localparam int DEF_FIELD_X0 = 240;
    localparam int DEF_FIELD_Y0 = 80;
    localparam int DEF_COLS     = 10;
    localparam int DEF_ROWS     = 20;
    localparam int DEF_BORDER   = 2;

    localparam colour_t COLOUR_BLACK = 3'b000;
    localparam colour_t COLOUR_WHITE = 3'b111;

endpackage

// File: rtl/shade_palette.sv
// Combinational map from a glyph pixel shade to an RGB colour.
//   shade        : 2-bit shade code from the glyph row
//   tile_colour  : colour stored with the board entry
//   code_is_zero : empty cell; always renders as background
//   colour       : resulting pixel colour
module shade_palette
    import petris_pkg::*;
#(
    parameter colour_t BG_COLOUR = COLOUR_BLACK
) (
    input  shade_t  shade,
    input  colour_t tile_colour,
    input  logic    code_is_zero,
    output colour_t colour
);

    always_comb begin
        colour = BG_COLOUR;
        if (!code_is_zero) begin
            case (shade)
                SHADE_BG:    colour = BG_COLOUR;
                SHADE_TILE:  colour = tile_colour;
                SHADE_WHITE: colour = COLOUR_WHITE;
                SHADE_BLACK: colour = COLOUR_BLACK;
            endcase
        end
    end

endmodule

// File: rtl/tile_renderer.sv
// Playfield pixel generator feeding the VGA output stage. Looks up the tile
// under the scan position in board RAM, then the glyph row in glyph ROM, and
// emits one RGB pixel per clock with sync/blank delayed to match.
// Latency from the edge that samples pixel_x/pixel_y to the outputs is 3.
//   clock, reset          : pixel clock, synchronous active-high reset
//   pixel_x, pixel_y      : scan position
//   active_in             : visible region
//   hsync_in, vsync_in    : raw syncs, active-low
//   board_addr            : board RAM address (combinational), row*COLS+col
//   board_data            : {colour[2:0], code[7:0]}, one cycle after address
//   glyph_addr            : {code, sub_row}, registered
//   glyph_data            : glyph row, one cycle after address
//   pixel                 : RGB pixel, registered
//   hsync_out, vsync_out  : syncs aligned with pixel
//   active_out            : visible flag aligned with pixel
module tile_renderer
    import petris_pkg::*;
#(
    parameter int      FIELD_X0      = DEF_FIELD_X0,
    parameter int      FIELD_Y0      = DEF_FIELD_Y0,
    parameter int      COLS          = DEF_COLS,
    parameter int      ROWS          = DEF_ROWS,
    parameter int      BORDER        = DEF_BORDER,
    parameter colour_t BG_COLOUR     = 3'b000,
    parameter colour_t BORDER_COLOUR = 3'b111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [7:0]  board_addr,
    input  logic [10:0] board_data,
    output logic [10:0] glyph_addr,
    input  logic [15:0] glyph_data,
    output colour_t     pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_out
);

    localparam logic [9:0] X_LO  = 10'(FIELD_X0);
    localparam logic [9:0] X_HI  = 10'(FIELD_X0 + COLS * TILE_PIX);
    localparam logic [9:0] Y_LO  = 10'(FIELD_Y0);
    localparam logic [9:0] Y_HI  = 10'(FIELD_Y0 + ROWS * TILE_PIX);
    localparam logic [9:0] BX_LO = 10'(FIELD_X0 - BORDER);
    localparam logic [9:0] BX_HI = 10'(FIELD_X0 + COLS * TILE_PIX + BORDER);
    localparam logic [9:0] BY_LO = 10'(FIELD_Y0 - BORDER);
    localparam logic [9:0] BY_HI = 10'(FIELD_Y0 + ROWS * TILE_PIX + BORDER);

    // Glyph pixel i occupies bits [15-2i -: 2]; leftmost pixel in the MSBs.
    function automatic shade_t glyph_shade(input logic [15:0] row_bits,
                                           input logic [2:0]  idx);
        logic [3:0] msb;
        msb = 4'd15 - {idx, 1'b0};
        return shade_t'(row_bits[msb -: 2]);
    endfunction

    logic [9:0]            rel_x, rel_y;
    logic                  in_field, in_box;
    logic [9-TILE_SHIFT:0] col, row;
    logic [7:0]            col_w, row_w;
    region_t               region_in;

    // rel_x/rel_y wrap when left of or above the field; in_field masks that.
    assign rel_x    = pixel_x - X_LO;
    assign rel_y    = pixel_y - Y_LO;
    assign in_field = (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                      (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    assign in_box   = (pixel_x >= BX_LO) && (pixel_x < BX_HI) &&
                      (pixel_y >= BY_LO) && (pixel_y < BY_HI);
    assign col      = rel_x[9:TILE_SHIFT];
    assign row      = rel_y[9:TILE_SHIFT];
    assign col_w    = 8'(col);
    assign row_w    = 8'(row);

    // row*10 as row*8 + row*2 keeps the address path adder-only.
    assign board_addr = in_field ? ((row_w << 3) + (row_w << 1) + col_w) : 8'd0;

    always_comb begin
        region_in = REGION_OUTSIDE;
        if (in_field)
            region_in = REGION_FIELD;
        else if (in_box)
            region_in = REGION_BORDER;
    end

    logic [2:0] sub_row_p0, sub_col_p0, sub_col_p1, sub_col_p2;
    region_t    region_p0, region_p1, region_p2;
    logic       active_p0, active_p1, active_p2;
    logic       hsync_p0, hsync_p1, hsync_p2;
    logic       vsync_p0, vsync_p1, vsync_p2;
    colour_t    colour_p1, colour_p2;
    logic       zero_p1, zero_p2;
    shade_t     shade_p2;
    colour_t    palette_colour, pixel_next;

    assign shade_p2 = glyph_shade(glyph_data, sub_col_p2);

    shade_palette #(
        .BG_COLOUR (BG_COLOUR)
    ) u_palette (
        .shade        (shade_p2),
        .tile_colour  (colour_p2),
        .code_is_zero (zero_p2),
        .colour       (palette_colour)
    );

    always_comb begin
        pixel_next = COLOUR_BLACK;
        if (active_p2) begin
            case (region_p2)
                REGION_BORDER: pixel_next = BORDER_COLOUR;
                REGION_FIELD:  pixel_next = palette_colour;
                default:       pixel_next = BG_COLOUR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sub_row_p0 <= '0;
            sub_col_p0 <= '0;
            region_p0  <= REGION_OUTSIDE;
            active_p0  <= 1'b0;
            hsync_p0   <= 1'b1;
            vsync_p0   <= 1'b1;
            glyph_addr <= '0;
            colour_p1  <= '0;
            zero_p1    <= 1'b0;
            sub_col_p1 <= '0;
            region_p1  <= REGION_OUTSIDE;
            active_p1  <= 1'b0;
            hsync_p1   <= 1'b1;
            vsync_p1   <= 1'b1;
            colour_p2  <= '0;
            zero_p2    <= 1'b0;
            sub_col_p2 <= '0;
            region_p2  <= REGION_OUTSIDE;
            active_p2  <= 1'b0;
            hsync_p2   <= 1'b1;
            vsync_p2   <= 1'b1;
            pixel      <= COLOUR_BLACK;
            active_out <= 1'b0;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
        end else begin
            // p0: scan position captured alongside the board RAM read
            sub_row_p0 <= rel_y[3:1];
            sub_col_p0 <= rel_x[3:1];
            region_p0  <= region_in;
            active_p0  <= active_in;
            hsync_p0   <= hsync_in;
            vsync_p0   <= vsync_in;
            // p1: board entry arrives, glyph ROM address issued
            glyph_addr <= {board_data[ENTRY_CODE_HI:ENTRY_CODE_LO], sub_row_p0};
            colour_p1  <= board_data[ENTRY_COLOUR_HI:ENTRY_COLOUR_LO];
            zero_p1    <= (board_data[ENTRY_CODE_HI:ENTRY_CODE_LO] == 8'd0);
            sub_col_p1 <= sub_col_p0;
            region_p1  <= region_p0;
            active_p1  <= active_p0;
            hsync_p1   <= hsync_p0;
            vsync_p1   <= vsync_p0;
            // p2: side data waits for the glyph row
            colour_p2  <= colour_p1;
            zero_p2    <= zero_p1;
            sub_col_p2 <= sub_col_p1;
            region_p2  <= region_p1;
            active_p2  <= active_p1;
            hsync_p2   <= hsync_p1;
            vsync_p2   <= vsync_p1;
            // p3: final pixel
            pixel      <= pixel_next;
            active_out <= active_p2;
            hsync_out  <= hsync_p2;
            vsync_out  <= vsync_p2;
        end
    end

endmodule
